cceip_outbound: RTL and testbench

//  Return path of the CCEIP kernel wrapper, opposite end of cceip_inbound: accepts the engine's
//  64-bit output stream (cceip_s_axis), forwards it to the memory-writer stream (mm_m_axis), counts

---
 rtl/cceip_kernel_pkg.sv | 27 ++
 rtl/cceip_outbound_if.sv | 21 ++
 rtl/cceip_axis_skid.sv | 60 ++++++
 rtl/cceip_outbound.sv | 101 ++++++++++
 tb/tb_cceip_outbound.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cceip_kernel_pkg.sv
// Shared types for the CCEIP kernel wrapper return path.
// Outbound FSM states, beat bundle and lane helpers.
package cceip_kernel_pkg;

    localparam int BYTES_PER_BEAT = 8;

    typedef enum logic [1:0] {
        OB_IDLE,
        OB_RUN,
        OB_FLUSH,
        OB_DONE
    } ob_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } axis_beat_t;

    function automatic logic [3:0] strb_bytes(input logic [7:0] strb);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++)
            n = n + {3'b000, strb[i]};
        return n;
    endfunction

endpackage

// File: rtl/cceip_outbound_if.sv
// AXI-stream bundle used on both sides of the outbound path.
// The master drives payload/valid, the slave drives ready.
interface cceip_outbound_if #(
    parameter int DATA_W = 64
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [7:0]        tstrb;
    logic              tlast;
    logic              tready;

    modport master (
        output tvalid, tdata, tstrb, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tlast,
        output tready
    );
endinterface

// File: rtl/cceip_axis_skid.sv
// Small circular skid buffer with a registered input ready.
// Head entry is presented directly, so payload stays stable while stalled.
module cceip_axis_skid
    import cceip_kernel_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  axis_beat_t s_beat,
    output logic       s_ready,
    output logic       m_valid,
    output axis_beat_t m_beat,
    input  logic       m_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    axis_beat_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    assign push      = s_valid && s_ready;
    assign pop       = m_valid && m_ready;
    assign m_valid   = (count != '0);
    assign m_beat    = mem[rd_ptr];
    assign count_nxt = count + CW'(push) - CW'(pop);

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_beat;
    end

    // Ready is a flop: look ahead at next occupancy to keep 1 beat/cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            count   <= count_nxt;
            s_ready <= (count_nxt < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/cceip_outbound.sv
// CCEIP return path: engine stream -> memory-writer stream.
// Counts result bytes, enforces buffer capacity, signals job completion.
module cceip_outbound
    import cceip_kernel_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int SKID_DEPTH = 2
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    outbound_start,
    input  logic [63:0]             output_buffer_size,
    cceip_outbound_if.slave         cceip_s_axis,
    cceip_outbound_if.master        mm_m_axis,
    output logic [63:0]             output_data_size,
    output logic                    outbound_overflow,
    output logic                    outbound_done
);
    ob_state_t   st_q;
    ob_state_t   st_nxt;
    logic [63:0] size_q;
    logic [63:0] beats_q;
    logic        skid_ready;
    logic        skid_valid;
    axis_beat_t  skid_out;
    axis_beat_t  fwd_beat;
    logic        accept;
    logic        fits;
    logic        fwd;
    logic        start_ok;

    assign start_ok = (st_q == OB_IDLE) && outbound_start;
    assign accept   = cceip_s_axis.tvalid && cceip_s_axis.tready;
    assign fits     = (beats_q * 64'(BYTES_PER_BEAT)) < size_q;
    assign fwd      = accept && fits;

    assign cceip_s_axis.tready = (st_q == OB_RUN) && skid_ready;
    assign outbound_done       = (st_q == OB_DONE);

    assign fwd_beat.data = cceip_s_axis.tdata[DATA_W-1:0];
    assign fwd_beat.last = cceip_s_axis.tlast;

    assign mm_m_axis.tvalid = skid_valid;
    assign mm_m_axis.tdata  = skid_out.data;
    assign mm_m_axis.tlast  = skid_out.last;
    assign mm_m_axis.tstrb  = 8'hFF;

    cceip_axis_skid #(
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (ap_clk),
        .rst     (areset),
        .s_valid (fwd),
        .s_beat  (fwd_beat),
        .s_ready (skid_ready),
        .m_valid (skid_valid),
        .m_beat  (skid_out),
        .m_ready (mm_m_axis.tready)
    );

    always_ff @(posedge ap_clk) begin
        if (areset)
            st_q <= OB_IDLE;
        else
            st_q <= st_nxt;
    end

    always_comb begin
        st_nxt = st_q;
        unique case (st_q)
            OB_IDLE:  if (start_ok) st_nxt = OB_RUN;
            OB_RUN:   if (accept && cceip_s_axis.tlast) st_nxt = OB_FLUSH;
            OB_FLUSH: if (!skid_valid) st_nxt = OB_DONE;
            OB_DONE:  st_nxt = OB_IDLE;
            default:  st_nxt = OB_IDLE;
        endcase
    end

    // Over-capacity beats are still drained from the engine, just not stored.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            size_q            <= '0;
            beats_q           <= '0;
            output_data_size  <= '0;
            outbound_overflow <= 1'b0;
        end else if (start_ok) begin
            size_q            <= output_buffer_size;
            beats_q           <= '0;
            output_data_size  <= '0;
            outbound_overflow <= 1'b0;
        end else if (accept) begin
            output_data_size <= output_data_size
                + 64'(strb_bytes(cceip_s_axis.tstrb));
            if (fits)
                beats_q <= beats_q + 64'd1;
            else
                outbound_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cceip_outbound.sv
// Directed bench for cceip_outbound: capacity, strobes, backpressure,
// reset abort and start filtering, checked with immediate assertions.
module tb_cceip_outbound;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        outbound_start;
    logic [63:0] output_buffer_size;
    logic [63:0] output_data_size;
    logic        outbound_overflow;
    logic        outbound_done;

    cceip_outbound_if s_if ();
    cceip_outbound_if m_if ();

    cceip_outbound dut (
        .ap_clk             (ap_clk),
        .areset             (areset),
        .outbound_start     (outbound_start),
        .output_buffer_size (output_buffer_size),
        .cceip_s_axis       (s_if),
        .mm_m_axis          (m_if),
        .output_data_size   (output_data_size),
        .outbound_overflow  (outbound_overflow),
        .outbound_done      (outbound_done)
    );

    always #5 ap_clk = ~ap_clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          done_cnt  = 0;
    int          done_base = 0;
    int          stalls    = 0;
    logic        tgl = 1'b0;
    logic [63:0] qd[$];
    logic        ql[$];
    int          qc[$];

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (!areset && m_if.tvalid && m_if.tready) begin
            qd.push_back(m_if.tdata);
            ql.push_back(m_if.tlast);
            qc.push_back(cyc);
        end
        if (!areset && outbound_done)
            done_cnt <= done_cnt + 1;
    end

    always @(negedge ap_clk)
        if (tgl) m_if.tready = ~m_if.tready;

    task automatic tick(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_q();
        qd.delete();
        ql.delete();
        qc.delete();
    endtask

    task automatic start_job(input logic [63:0] sz);
        done_base          = done_cnt;
        output_buffer_size = sz;
        outbound_start     = 1'b1;
        tick(1);
        outbound_start     = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] strb,
                        input logic last);
        int n;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tstrb  = strb;
        s_if.tlast  = last;
        while (!s_if.tready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
        stalls += n;
        tick(1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(n < 200), 64'd1);
        tick(3);
        chk({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
    endtask

    initial begin
        areset             = 1'b1;
        outbound_start     = 1'b0;
        output_buffer_size = '0;
        s_if.tvalid        = 1'b0;
        s_if.tdata         = '0;
        s_if.tstrb         = '0;
        s_if.tlast         = 1'b0;
        m_if.tready        = 1'b1;
        tick(3);
        chk("rst_tready", 64'(s_if.tready), 64'd0);
        chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_size", output_data_size, 64'd0);
        chk("rst_ovf", 64'(outbound_overflow), 64'd0);
        chk("rst_done", 64'(outbound_done), 64'd0);
        areset = 1'b0;
        tick(2);

        // 1: eight full beats into a 64-byte buffer
        clr_q();
        start_job(64'd64);
        for (int i = 0; i < 8; i++)
            send(64'h1000 + 64'(i), 8'hFF, i == 7);
        wait_done("t1");
        chk("t1_count", 64'(qd.size()), 64'd8);
        if (qd.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t1_data%0d", i), qd[i], 64'h1000 + 64'(i));
                chk($sformatf("t1_last%0d", i), 64'(ql[i]), 64'(i == 7));
            end
            chk("t1_rate", 64'(qc[7] - qc[0]), 64'd7);
        end
        chk("t1_size", output_data_size, 64'd64);
        chk("t1_ovf", 64'(outbound_overflow), 64'd0);

        // 2: partial last beat
        clr_q();
        start_job(64'd64);
        send(64'hA0, 8'hFF, 1'b0);
        send(64'hA1, 8'hFF, 1'b0);
        send(64'hA2, 8'h07, 1'b1);
        wait_done("t2");
        chk("t2_size", output_data_size, 64'd19);
        chk("t2_count", 64'(qd.size()), 64'd3);
        if (qd.size() == 3) chk("t2_last", 64'(ql[2]), 64'd1);

        // 3: 16-byte buffer, four beats -> overflow
        clr_q();
        start_job(64'd16);
        for (int i = 0; i < 4; i++)
            send(64'hB0 + 64'(i), 8'hFF, i == 3);
        wait_done("t3");
        chk("t3_count", 64'(qd.size()), 64'd2);
        if (qd.size() == 2) begin
            chk("t3_data1", qd[1], 64'hB1);
            chk("t3_nolast", 64'(ql[0] | ql[1]), 64'd0);
        end
        chk("t3_size", output_data_size, 64'd32);
        chk("t3_ovf", 64'(outbound_overflow), 64'd1);

        // 4: toggling writer ready
        clr_q();
        stalls = 0;
        start_job(64'd64);
        tgl = 1'b1;
        for (int i = 0; i < 6; i++)
            send(64'hC0DE_0000 + 64'(i), 8'hFF, i == 5);
        wait_done("t4");
        tgl = 1'b0;
        m_if.tready = 1'b1;
        chk("t4_count", 64'(qd.size()), 64'd6);
        if (qd.size() == 6)
            for (int i = 0; i < 6; i++)
                chk($sformatf("t4_data%0d", i), qd[i], 64'hC0DE_0000 + 64'(i));
        chk("t4_stalled", 64'(stalls > 0), 64'd1);
        chk("t4_size", output_data_size, 64'd48);

        // 5: reset mid-job aborts
        start_job(64'd64);
        for (int i = 0; i < 3; i++)
            send(64'hD0 + 64'(i), 8'hFF, 1'b0);
        areset = 1'b1;
        tick(1);
        chk("t5_tready", 64'(s_if.tready), 64'd0);
        chk("t5_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("t5_size", output_data_size, 64'd0);
        chk("t5_ovf", 64'(outbound_overflow), 64'd0);
        chk("t5_done", 64'(outbound_done), 64'd0);
        areset = 1'b0;
        tick(2);
        clr_q();
        start_job(64'd64);
        send(64'hE0, 8'hFF, 1'b0);
        send(64'hE1, 8'hFF, 1'b1);
        wait_done("t5");
        chk("t5_size2", output_data_size, 64'd16);
        chk("t5_count", 64'(qd.size()), 64'd2);
        if (qd.size() == 2) chk("t5_data0", qd[0], 64'hE0);

        // 6: engine valid before start, start during RUN
        clr_q();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'hF00;
        s_if.tstrb  = 8'hFF;
        tick(3);
        chk("t6_idle_tready", 64'(s_if.tready), 64'd0);
        s_if.tvalid = 1'b0;
        tick(1);
        chk("t6_idle_fwd", 64'(qd.size()), 64'd0);
        start_job(64'd64);
        send(64'hF1, 8'hFF, 1'b0);
        outbound_start     = 1'b1;
        output_buffer_size = 64'd0;
        tick(1);
        outbound_start     = 1'b0;
        send(64'hF2, 8'hFF, 1'b1);
        wait_done("t6");
        chk("t6_size", output_data_size, 64'd16);
        chk("t6_ovf", 64'(outbound_overflow), 64'd0);
        chk("t6_count", 64'(qd.size()), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
